// File: rtl/dmem_responder.sv
// Data-memory responder for the pipeline memory stage.
// Captures one load/store request, holds the pipeline for WAIT_STATES cycles,
// then completes the access in a single RESP cycle. Stores are byte-lane
// masked; loads come back sign- or zero-extended to 32 bits.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        mem_stall,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        misalign_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;
    localparam bit ZERO_WAIT = (WAIT_STATES == 0);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [AW+1:0]     addr_reg;
    logic [31:0]       wdata_reg;
    logic [1:0]        size_reg;
    logic              unsigned_reg;
    logic              write_reg;

    // Upper address bits are deliberately ignored: addresses alias modulo the array.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:AW+2];

    logic req_any;
    logic is_idle;
    assign req_any = req_read | req_write;
    assign is_idle = (state_reg == ST_IDLE);

    // With zero wait states the access completes on the capture edge, so the
    // "active" request comes straight from the inputs while idle and from the
    // captured copy otherwise.
    logic [AW+1:0] act_addr;
    logic [31:0]   act_wdata;
    logic [1:0]    act_size;
    logic          act_unsigned;
    logic          act_write;
    logic [AW-1:0] act_idx;
    logic [1:0]    act_lane;
    logic          act_misaligned;
    logic          enter_resp;

    assign act_addr     = is_idle ? req_addr[AW+1:0] : addr_reg;
    assign act_wdata    = is_idle ? req_wdata        : wdata_reg;
    assign act_size     = is_idle ? req_size         : size_reg;
    assign act_unsigned = is_idle ? req_unsigned     : unsigned_reg;
    assign act_write    = is_idle ? req_write        : write_reg;
    assign act_idx      = act_addr[AW+1:2];
    assign act_lane     = act_addr[1:0];

    assign act_misaligned = (act_size == 2'b11)
                          || ((act_size == SZ_HALF) && act_addr[0])
                          || ((act_size == SZ_WORD) && (act_addr[1:0] != 2'b00));

    assign enter_resp = (is_idle && req_any && ZERO_WAIT)
                      || ((state_reg == ST_WAIT) && (cnt_reg == '0));

    // Lane enables and lane-replicated write data for the committing store.
    logic [3:0]  lane_we;
    logic [31:0] lane_wdata;
    always_comb begin
        lane_we    = 4'b0000;
        lane_wdata = act_wdata;
        case (act_size)
            SZ_BYTE: lane_wdata = {4{act_wdata[7:0]}};
            SZ_HALF: lane_wdata = {2{act_wdata[15:0]}};
            default: lane_wdata = act_wdata;
        endcase
        if (enter_resp && act_write && !act_misaligned) begin
            case (act_size)
                SZ_BYTE: lane_we = 4'b0001 << act_lane;
                SZ_HALF: lane_we = act_lane[1] ? 4'b1100 : 4'b0011;
                SZ_WORD: lane_we = 4'b1111;
                default: lane_we = 4'b0000;
            endcase
        end
    end

    // One byte-wide array per lane; read data is consumed only on the edge
    // entering RESP, where it is registered into resp_rdata.
    logic [31:0] rd_word;
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH_WORDS];

            // Lane storage: cleared on reset, written when its enable fires.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH_WORDS; i++) begin
                        lane_mem[i] <= 8'h00;
                    end
                end else if (lane_we[gi]) begin
                    lane_mem[act_idx] <= lane_wdata[gi*8 +: 8];
                end
            end

            assign rd_word[gi*8 +: 8] = lane_mem[act_idx];
        end
    endgenerate

    // Extract the addressed byte/half and extend it.
    logic [31:0] shifted;
    logic [31:0] load_data;
    always_comb begin
        shifted   = rd_word >> {act_lane, 3'b000};
        load_data = '0;
        case (act_size)
            SZ_BYTE: load_data = {{24{~act_unsigned & shifted[7]}}, shifted[7:0]};
            SZ_HALF: load_data = {{16{~act_unsigned & shifted[15]}}, shifted[15:0]};
            SZ_WORD: load_data = rd_word;
            default: load_data = '0;
        endcase
    end

    // Pipeline hold: follows the request while idle, forced high while waiting.
    always_comb begin
        mem_stall = 1'b0;
        if (!rst) begin
            case (state_reg)
                ST_IDLE: mem_stall = req_any;
                ST_WAIT: mem_stall = 1'b1;
                default: mem_stall = 1'b0;
            endcase
        end
    end

    // Control FSM with request capture and registered response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            size_reg     <= '0;
            unsigned_reg <= 1'b0;
            write_reg    <= 1'b0;
            resp_valid   <= 1'b0;
            resp_rdata   <= '0;
            misalign_err <= 1'b0;
        end else begin
            resp_valid   <= 1'b0;
            misalign_err <= 1'b0;
            if (enter_resp) begin
                resp_valid   <= 1'b1;
                misalign_err <= act_misaligned;
                resp_rdata   <= (!act_write && !act_misaligned) ? load_data : '0;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (req_any) begin
                        addr_reg     <= req_addr[AW+1:0];
                        wdata_reg    <= req_wdata;
                        size_reg     <= req_size;
                        unsigned_reg <= req_unsigned;
                        write_reg    <= req_write;
                        cnt_reg      <= CNT_INIT;
                        state_reg    <= ZERO_WAIT ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_reg == '0) begin
                        state_reg <= ST_RESP;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                ST_RESP: state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder serving the load/store requests issued by the pipeline's memory stage. It captures each request (address, store data, size, signedness) and inserts a configurable number of wait states. During those cycles it holds the pipeline with a stall signal, then completes the access: stores use byte-lane writes, loads return sign- or zero-extended data. The block sits between the EX/MEM pipeline register outputs and the MEM/WB register input, replacing the single-cycle data memory.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words; power of two, minimum 4.
WAIT_STATES, 2, cycles spent in WAIT before the response; 0 is legal.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous active-high reset.
req_read  input  1  load request, held by the requester until the stall drops.
req_write  input  1  store request, held by the requester until the stall drops.
req_addr  input  32  byte address (ALU result).
req_wdata  input  32  store data (rs2 value); byte/half taken from the low bits.
req_size  input  2  00 byte, 01 half, 10 word, 11 reserved (funct3[1:0]).
req_unsigned  input  1  load zero-extends when 1 (funct3[2]).
mem_stall  output  1  pipeline hold request.
resp_valid  output  1  one-cycle completion pulse.
resp_rdata  output  32  extended load data, valid with resp_valid.
misalign_err  output  1  one-cycle error pulse, coincident with resp_valid.

Behaviour:
- Clock is clk. Reset is synchronous, active-high, named rst.
- Reset:
  - FSM goes to IDLE.
  - mem_stall=0, resp_valid=0, resp_rdata=0, misalign_err=0.
  - All memory words cleared to 0.
  - Reset asserted mid-operation abandons the pending access. A pending store is discarded and never written.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - mem_stall = req_read | req_write (combinational, same cycle).
  - On a request, the edge captures addr, wdata, size, unsigned and op. Write has priority if both req_read and req_write are high; the op is then a store.
  - Next state is WAIT with counter = WAIT_STATES-1, or RESP directly if WAIT_STATES=0.
- WAIT:
  - mem_stall=1.
  - Counter decrements each cycle; when it reaches 0, next state is RESP.
  - Request inputs are ignored.
- RESP (exactly one cycle):
  - mem_stall=0 and resp_valid=1.
  - Next state is IDLE unconditionally, so the request visible in the RESP cycle is the same request and is not re-accepted.
- Latency: a request first seen in cycle T produces resp_valid in cycle T+WAIT_STATES+1. mem_stall is high in cycles T..T+WAIT_STATES.
- Store commit:
  - Occurs on the edge entering RESP.
  - Byte writes lane addr[1:0]; half writes lanes {addr[1],0} and {addr[1],1}; word writes all four lanes. Lane 0 is bits 7:0 (little-endian).
- Load data:
  - Read from the array on the edge entering RESP and registered into resp_rdata.
  - Byte/half are extended from bit 7/15; sign-extended unless unsigned.
  - resp_rdata holds its value until the next load response. For stores it is 0 in RESP.
- Misalignment: half with addr[0]=1, word with addr[1:0]!=0, or size=11.
  - No array access occurs; the store is dropped.
  - misalign_err=1 and resp_rdata=0 in RESP.
- Addressing:
  - Word index = addr[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so out-of-range addresses alias (wrap modulo the array size).
- misalign_err and resp_valid are registered outputs. mem_stall is combinational from the state and the request inputs.

Test Plan:
- Reset then idle: rst=1 for 2 cycles with req_read=1 -> mem_stall=0, resp_valid=0, resp_rdata=0. Word read of 0x0 after reset returns 0x00000000.
- Word store/load, WAIT_STATES=2: store 0xDEADBEEF to 0x10 -> mem_stall high 3 cycles, resp_valid in cycle T+3. Word load of 0x10 -> resp_rdata=0xDEADBEEF in cycle T+3.
- Byte/half lanes and extension:
  - Byte store 0x80 to 0x13 -> load word 0x10 returns 0x80ADBEEF.
  - Signed byte load 0x13 -> 0xFFFFFF80; unsigned -> 0x00000080.
  - Signed half load 0x12 -> 0xFFFF80AD.
- Misalignment: word load at 0x12 -> misalign_err=1, resp_rdata=0. Half store 0xAAAA at 0x11 -> word 0x10 unchanged (0x80ADBEEF).
- Reset mid-WAIT: store 0x12345678 to 0x20, assert rst in the first WAIT cycle -> FSM goes to IDLE, mem_stall=0, no resp_valid. A later load of 0x20 returns 0.
- Zero wait states and back-to-back: WAIT_STATES=0; store to 0x4 then immediately load 0x4 -> each completes 1 cycle after its request and the load returns the stored word. With DEPTH_WORDS=256, a load at 0x404 aliases to 0x4.
